mux_scan_sel: RTL
=================

Name: mux_scan_sel

Overview:
Parametrised N-channel, W-bit registered channel selector. It is the successor to the fixed 16:1 single-bit combinational mux.
- Manual mode: the output follows an external select input.
- Scan mode: the block steps round-robin through all channels, dwelling a programmable number of cycles on each.
- Sits between sensor/switch input banks and the display/UART paths, so those paths can sample every channel without external sequencing logic.

Parameters:
CH, 16, number of input channels (2..256)
W, 1, bits per channel
SELW, 4, select/pointer width; must satisfy 2**SELW >= CH
DWELL, 8, cycles spent on each channel in scan mode (>= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
data  in  CH*W  channel inputs; channel i occupies data[i*W +: W]
sel  in  SELW  manual channel select
mode  in  1  0 = manual, 1 = scan
hold  in  1  1 = freeze all state and outputs
dout  out  W  registered selected channel data
dout_ch  out  SELW  channel index currently driving dout
dout_vld  out  1  dout holds valid channel data
wrap  out  1  one-cycle pulse when the scan pointer wraps to channel 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all of the following clear immediately on rst, independent of clk:
  - dout=0, dout_ch=0, dout_vld=0, wrap=0
  - scan pointer ptr=0, dwell counter cnt=0
  - FSM enters MANUAL
- FSM states: MANUAL, SCAN.
  - MANUAL -> SCAN on mode=1 with hold=0. Transition cycle loads ptr=0, cnt=0, and registers dout=data[ch0].
  - SCAN -> MANUAL on mode=0 with hold=0. The next registered dout follows sel.
- MANUAL, each cycle with hold=0 (latency 1 cycle):
  - dout <= data[sel], dout_ch <= sel, dout_vld <= 1.
  - If sel >= CH: dout <= 0, dout_ch <= sel, dout_vld <= 0.
- SCAN, each cycle with hold=0:
  - dout <= data[ptr] (live tracking during the dwell), dout_ch <= ptr, dout_vld <= 1.
  - cnt increments each cycle.
  - When cnt == DWELL-1: cnt <= 0 and ptr advances.
  - ptr == CH-1 advances to 0; wrap is asserted for exactly the cycle in which dout_ch first shows 0 after the wrap.
  - wrap is 0 in all other cycles, in MANUAL, and on SCAN entry.
  - DWELL=1: ptr advances every cycle.
  - Non-power-of-two CH: ptr never reaches values >= CH.
- hold=1 freezes FSM state, ptr, cnt, dout, dout_ch and dout_vld; wrap is forced to 0.
  - mode and sel are ignored while hold=1 and sampled on the first cycle after release.
  - Scan resumes mid-dwell with the remaining count intact.
- Reset mid-scan: aborts immediately; after release the block restarts in MANUAL.
- data changes mid-dwell appear on dout 1 cycle later.

Optional Feature:
Macro MUX_SCAN_SEL_MASK_EN.
- Defined: adds input port ch_en [CH] (per-channel enable).
  - Scan skips disabled channels: ptr advances to the next enabled index, wrapping past CH-1.
  - wrap pulses whenever the advance crosses from a higher index to a lower-or-equal one.
  - Entering SCAN starts at the lowest enabled channel.
  - All channels disabled: dout=0, dout_vld=0, wrap=0, ptr holds.
  - MANUAL select of a disabled channel: dout=0, dout_vld=0, dout_ch=sel.
  - ch_en changes take effect at the next pointer advance.
- Undefined: no ch_en port; all channels treated as enabled; behaviour exactly as above.

Test Plan:
All tests use CH=16, W=8, DWELL=4, with data channel i = 8'hA0+i.
- Reset/manual: assert rst, then release; set sel=5 -> 1 cycle later dout=8'hA5, dout_ch=5, dout_vld=1. Set sel=15 -> dout=8'hAF the next cycle.
- Scan sweep: mode=1 for 64 cycles -> dout_ch holds each value 0..15 for 4 cycles in order. wrap is a single-cycle pulse exactly when dout_ch returns to 0 (cycle 65). Values track 8'hA0..8'hAF.
- Hold: in scan, assert hold at ch 3 with cnt=1 for 10 cycles -> all outputs frozen, wrap=0. On release, ch 3 persists 2 more cycles, then ch 4.
- Async reset mid-scan: pulse rst between clock edges at ch 7 -> outputs go to 0 before the next edge; after release, state is MANUAL and dout follows sel.
- Mode switch and out-of-range select: rebuild with CH=12, SELW=4.
  - Manual sel=13 -> dout=0, dout_vld=0.
  - Scan -> ptr wraps from 11 to 0, never shows 12..15.
  - Mode=0 mid-dwell -> the next cycle follows sel.
- Mask (MUX_SCAN_SEL_MASK_EN defined): ch_en=16'h0011, scan -> ch 0 x4, then ch 4 x4, then ch 0 with wrap=1. ch_en=0 -> dout_vld=0, dout=0.

Source files
------------

// File: rtl/mux_scan_sel_if.sv
// Bundle of the channel-selector bus: channel data and controls going in,
// selected channel data and status coming out. The ch_en per-channel enable
// only exists when MUX_SCAN_SEL_MASK_EN is defined.
interface mux_scan_sel_if #(
  parameter int CH   = 16,
  parameter int W    = 1,
  parameter int SELW = 4
);
  logic [CH*W-1:0] data;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            hold;
`ifdef MUX_SCAN_SEL_MASK_EN
  logic [CH-1:0]   ch_en;
`endif
  logic [W-1:0]    dout;
  logic [SELW-1:0] dout_ch;
  logic            dout_vld;
  logic            wrap;

  // Producer side: drives channel data and controls, observes the selection
  modport master (
`ifdef MUX_SCAN_SEL_MASK_EN
    output ch_en,
`endif
    output data, sel, mode, hold,
    input  dout, dout_ch, dout_vld, wrap
  );

  // Selector side
  modport slave (
`ifdef MUX_SCAN_SEL_MASK_EN
    input  ch_en,
`endif
    input  data, sel, mode, hold,
    output dout, dout_ch, dout_vld, wrap
  );
endinterface

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-channel, W-bit channel selector.
// MANUAL mode follows the external select; SCAN mode walks round-robin over
// the channels, dwelling DWELL cycles on each and pulsing wrap on return to
// the lowest channel. hold freezes everything (wrap forced low).
// Optional feature macro: MUX_SCAN_SEL_MASK_EN adds the per-channel enable
// bus.ch_en; scan then skips disabled channels and manual select of a
// disabled channel yields invalid output. Without it every channel is enabled.
module mux_scan_sel #(
  parameter int CH    = 16,
  parameter int W     = 1,
  parameter int SELW  = 4,
  parameter int DWELL = 8
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_sel_if.slave bus
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t          state_p1;
  state_t          state_nxt;
  logic [SELW-1:0] ptr_p1;
  logic [SELW-1:0] ptr_nxt;
  logic [CNTW-1:0] cnt_p1;
  logic [CNTW-1:0] cnt_nxt;
  logic [W-1:0]    dout_p1;
  logic [W-1:0]    dout_nxt;
  logic [SELW-1:0] ch_p1;
  logic [SELW-1:0] ch_nxt;
  logic            vld_p1;
  logic            vld_nxt;
  logic            wrap_p1;
  logic            wrap_nxt;

  logic [CH-1:0]   en;
  logic            any_en;
  logic            sel_on;
  logic [SELW-1:0] first_ptr;
  logic [SELW-1:0] adv_ptr;

`ifdef MUX_SCAN_SEL_MASK_EN
  assign en = bus.ch_en;
`else
  assign en = '1;
`endif

  // Data of channel idx; indices at or above CH read as zero
  function automatic logic [W-1:0] pick_ch(input logic [CH*W-1:0] d,
                                           input logic [SELW-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(idx) == i) r = d[i*W +: W];
    end
    return r;
  endfunction

  // True when idx names an existing, enabled channel
  function automatic logic is_en(input logic [CH-1:0]   e,
                                 input logic [SELW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (int'(idx) == i) r = e[i];
    end
    return r;
  endfunction

  // Lowest enabled channel, 0 when none is enabled
  function automatic logic [SELW-1:0] first_en(input logic [CH-1:0] e);
    logic [SELW-1:0] r;
    r = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (e[i]) r = SELW'(i);
    end
    return r;
  endfunction

  // Next enabled channel after p in circular order; p itself when none
  function automatic logic [SELW-1:0] next_en(input logic [CH-1:0]   e,
                                              input logic [SELW-1:0] p);
    logic [SELW-1:0] r;
    logic            found;
    r     = p;
    found = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (e[i] && (i > int'(p))) begin
        r     = SELW'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = CH - 1; i >= 0; i--) begin
        if (e[i]) r = SELW'(i);
      end
    end
    return r;
  endfunction

  assign any_en    = |en;
  assign sel_on    = is_en(en, bus.sel);
  assign first_ptr = first_en(en);
  assign adv_ptr   = next_en(en, ptr_p1);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= MANUAL;
    else     state_p1 <= state_nxt;
  end

  // FSM next state: mode is only honoured while not held
  always_comb begin
    state_nxt = state_p1;
    if (!bus.hold) state_nxt = bus.mode ? SCAN : MANUAL;
  end

  // Next outputs and scan position: manual select, scan entry, or dwell/advance
  always_comb begin
    ptr_nxt  = ptr_p1;
    cnt_nxt  = cnt_p1;
    dout_nxt = dout_p1;
    ch_nxt   = ch_p1;
    vld_nxt  = vld_p1;
    wrap_nxt = 1'b0;
    if (!bus.hold) begin
      if (!bus.mode) begin
        // Manual, including the cycle that leaves scan
        ch_nxt = bus.sel;
        if (sel_on) begin
          dout_nxt = pick_ch(bus.data, bus.sel);
          vld_nxt  = 1'b1;
        end else begin
          dout_nxt = '0;
          vld_nxt  = 1'b0;
        end
      end else if (state_p1 == MANUAL) begin
        // Scan entry: this cycle is the first dwell cycle on the start channel
        ptr_nxt  = first_ptr;
        cnt_nxt  = '0;
        ch_nxt   = first_ptr;
        dout_nxt = any_en ? pick_ch(bus.data, first_ptr) : '0;
        vld_nxt  = any_en;
      end else if (!any_en) begin
        // Nothing to scan: park the pointer and report invalid data
        ch_nxt   = ptr_p1;
        dout_nxt = '0;
        vld_nxt  = 1'b0;
      end else begin
        if (cnt_p1 == CNT_LAST) begin
          cnt_nxt  = '0;
          ptr_nxt  = adv_ptr;
          wrap_nxt = (adv_ptr <= ptr_p1);
        end else begin
          cnt_nxt = cnt_p1 + 1'b1;
        end
        ch_nxt   = ptr_nxt;
        dout_nxt = pick_ch(bus.data, ptr_nxt);
        vld_nxt  = 1'b1;
      end
    end
  end

  // Output stage and scan position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p1  <= '0;
      cnt_p1  <= '0;
      dout_p1 <= '0;
      ch_p1   <= '0;
      vld_p1  <= 1'b0;
      wrap_p1 <= 1'b0;
    end else begin
      ptr_p1  <= ptr_nxt;
      cnt_p1  <= cnt_nxt;
      dout_p1 <= dout_nxt;
      ch_p1   <= ch_nxt;
      vld_p1  <= vld_nxt;
      wrap_p1 <= wrap_nxt;
    end
  end

  assign bus.dout     = dout_p1;
  assign bus.dout_ch  = ch_p1;
  assign bus.dout_vld = vld_p1;
  assign bus.wrap     = wrap_p1;

endmodule
